pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter register and fetch sequencer; sits directly upstream of the PC adder.
- Drives pc_out into the adder's first operand; the adder's second operand is tied to 32'd4.
- Consumes the adder result as pc_plus4 and selects the next PC from sequential, branch, jump and jump-register sources.
- Issues word fetches to instruction memory over a req/ready handshake; supports stalls and squashes wrong-path fetches.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word aligned.
ADDR_W, 32, PC/address width; only 32 is supported.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
pc_plus4  input  32  PC adder result; equals pc_out + 4 (mod 2^32).
branch_taken  input  1  conditional branch resolved taken this cycle.
branch_target  input  32  branch destination.
jump  input  1  unconditional jump this cycle.
jump_target  input  32  jump destination.
jr  input  1  jump-register this cycle.
jr_target  input  32  register-sourced destination.
stall  input  1  downstream cannot accept instructions.
imem_ready  input  1  instruction memory returns the word for imem_addr this cycle.
pc_out  output  32  current PC; feeds the PC adder.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address; always equals pc_out.
instr_valid  output  1  the returned word is on the correct path and is accepted.
misalign_err  output  1  sticky misaligned-target flag (optional feature only; otherwise tied to 0).

Behaviour:
- States: BOOT, FETCH, HOLD.
- Reset (asynchronous, immediate):
  - state=BOOT, pc_out=RESET_VECTOR, pend_valid=0, pend_target=0.
  - imem_req=0, instr_valid=0, misalign_err=0.
  - An in-flight request is abandoned.
- BOOT: imem_req=0 for exactly one cycle after rst deasserts, then FETCH.
- Redirect: redirect_now = jr | jump | branch_taken. Target priority jr > jump > branch_taken; lower-priority requests in the same cycle are ignored.
- next_pc selection: redirect_now ? priority target : pend_valid ? pend_target : pc_plus4.
- FETCH:
  - imem_req=1.
  - Completion is imem_ready=1. On completion:
    - pc_out <= next_pc on that edge.
    - pend_valid <= 0.
    - Next state is HOLD if stall=1, else FETCH.
  - instr_valid = FETCH & imem_ready & !redirect_now & !pend_valid (combinational, same cycle). Redirected or pending fetches are squashed.
  - No completion with redirect_now=1: pend_target <= priority target, pend_valid <= 1. A later redirect overwrites the pending target.
  - No completion with stall=1: go to HOLD. The request is withdrawn; memory must tolerate a dropped request.
- HOLD:
  - imem_req=0, pc_out held.
  - Redirects are captured into pending exactly as in FETCH.
  - When stall=0, go to FETCH next cycle.
  - Pending target in HOLD: on leaving HOLD, pc_out <= pend_target and pend_valid <= 0 before the first request. The first FETCH cycle therefore fetches the redirected address.
- Latency:
  - Sequential throughput is one instruction per cycle when imem_ready is held high.
  - A redirect on cycle N with completion appears on imem_addr at cycle N+1.
- Wrap-around: pc_out=32'hFFFF_FFFC, pc_plus4=0 → pc_out becomes 0; no error.
- Targets and pc_plus4 are used verbatim; the block performs no arithmetic.

Optional Feature:
PC_MISALIGN_CHECK_EN
- Defined:
  - A selected redirect target with bits[1:0]≠0 sets misalign_err=1, which is sticky until rst.
  - The offending target is not loaded; pc_out holds, the state goes to HOLD and stays there regardless of stall.
  - instr_valid=0 while misalign_err=1.
- Undefined: target bits[1:0] are forced to 2'b00 silently; misalign_err is constant 0.

Decomposition:
- Shared package pc_pkg: RESET_VECTOR default, INSTR_BYTES=4, fetch state enum {BOOT, FETCH, HOLD}, redirect-select encoding.
- One natural sub-module, pc_next_sel: purely combinational priority mux for jr/jump/branch/pending/pc_plus4.
- FSM, PC register and pending register stay in pc_fetch_ctrl.
- The bench instantiates the real PC adder to generate pc_plus4.

Test Plan:
- Reset then imem_ready=1 constant:
  - BOOT idles one cycle.
  - imem_addr sequence 0, 4, 8, 12.
  - instr_valid high each fetch cycle.
- jump=1, jump_target=32'h0000_0100 together with branch_taken=1, branch_target=32'h200 on a completion cycle:
  - instr_valid=0 that cycle.
  - Next imem_addr=32'h100.
- imem_ready=0 for 3 cycles at pc=32'h10, jr=1, jr_target=32'h40 in cycle 1:
  - Completion squashed (instr_valid=0).
  - Next imem_addr=32'h40.
- stall=1 for 4 cycles at pc=32'h20, branch_taken with target 32'h80 during HOLD:
  - imem_req=0 while stalled.
  - After release, first imem_addr=32'h80.
- RESET_VECTOR=32'hFFFF_FFF8, imem_ready=1: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted mid-wait at pc=32'h30: imem_req and pc_out drop to 0 and RESET_VECTOR without a clock edge. With PC_MISALIGN_CHECK_EN: jump_target=32'h102 → misalign_err=1, pc held, imem_req=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_pkg;

   localparam int unsigned PC_W        = 32;
   localparam int unsigned INSTR_BYTES = 4;

   localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [PC_W-1:0] ALIGN_MASK       = ~PC_W'(INSTR_BYTES - 1);

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      HOLD
   } fetch_state_t;

   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_PEND,
      SEL_BR,
      SEL_JMP,
      SEL_JR
   } next_sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: jr > jump > branch > pending > pc_plus4.
// PC_MISALIGN_CHECK_EN: report misaligned redirect targets instead of masking them.
module pc_next_sel
   import pc_pkg::*;
(
   input  logic            jr,
   input  logic [PC_W-1:0] jr_target,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            pend_valid,
   input  logic [PC_W-1:0] pend_target,
   input  logic [PC_W-1:0] pc_plus4,
   output logic            redirect_now,
   output logic            misaligned,
   output logic [PC_W-1:0] redirect_target,
   output logic [PC_W-1:0] next_pc
);

   next_sel_t       sel;
   logic [PC_W-1:0] raw_target;

   always_comb begin
      sel = SEL_SEQ;
      if (jr)                sel = SEL_JR;
      else if (jump)         sel = SEL_JMP;
      else if (branch_taken) sel = SEL_BR;
      else if (pend_valid)   sel = SEL_PEND;
   end

   always_comb begin
      raw_target = '0;
      case (sel)
         SEL_JR:  raw_target = jr_target;
         SEL_JMP: raw_target = jump_target;
         SEL_BR:  raw_target = branch_target;
         default: raw_target = '0;
      endcase
   end

   assign redirect_now = jr | jump | branch_taken;

`ifdef PC_MISALIGN_CHECK_EN
   assign redirect_target = raw_target;
   assign misaligned      = redirect_now && ((raw_target & ~ALIGN_MASK) != '0);
`else
   // Low address bits are dropped so a sloppy target still lands on a word.
   assign redirect_target = raw_target & ALIGN_MASK;
   assign misaligned      = 1'b0;
`endif

   always_comb begin
      next_pc = pc_plus4;
      case (sel)
         SEL_JR, SEL_JMP, SEL_BR: next_pc = redirect_target;
         SEL_PEND:                next_pc = pend_target;
         default:                 next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch sequencer (BOOT/FETCH/HOLD) with redirect capture.
// PC_MISALIGN_CHECK_EN enables the sticky misaligned-target trap.
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter int unsigned       ADDR_W       = PC_W,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_plus4,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              jr,
   input  logic [ADDR_W-1:0] jr_target,
   input  logic              stall,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] pc_out,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              instr_valid,
   output logic              misalign_err
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0] pend_target_q, pend_target_d;
   logic              redirect_now, misaligned, err;
   logic [ADDR_W-1:0] redirect_target, next_pc;

   pc_next_sel u_next_sel (
      .jr              (jr),
      .jr_target       (jr_target),
      .jump            (jump),
      .jump_target     (jump_target),
      .branch_taken    (branch_taken),
      .branch_target   (branch_target),
      .pend_valid      (pend_valid_q),
      .pend_target     (pend_target_q),
      .pc_plus4        (pc_plus4),
      .redirect_now    (redirect_now),
      .misaligned      (misaligned),
      .redirect_target (redirect_target),
      .next_pc         (next_pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= BOOT;
         pc_q          <= RESET_VECTOR;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

`ifdef PC_MISALIGN_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    err_q <= 1'b0;
      else if (state_q != BOOT && misaligned)     err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      case (state_q)
         BOOT: state_d = FETCH;
         FETCH: begin
            if (misaligned) begin
               state_d = HOLD;
            end else if (imem_ready) begin
               pc_d         = next_pc;
               pend_valid_d = 1'b0;
               state_d      = stall ? HOLD : FETCH;
            end else begin
               if (redirect_now) begin
                  pend_target_d = redirect_target;
                  pend_valid_d  = 1'b1;
               end
               if (stall) state_d = HOLD;
            end
         end
         HOLD: begin
            // A trapped fetcher parks here until reset.
            if (err || misaligned) begin
               state_d = HOLD;
            end else if (!stall) begin
               state_d = FETCH;
               if (redirect_now || pend_valid_q) begin
                  pc_d         = next_pc;
                  pend_valid_d = 1'b0;
               end
            end else if (redirect_now) begin
               pend_target_d = redirect_target;
               pend_valid_d  = 1'b1;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   assign pc_out       = pc_q;
   assign imem_addr    = pc_q;
   assign imem_req     = (state_q == FETCH);
   assign instr_valid  = (state_q == FETCH) & imem_ready & ~redirect_now & ~pend_valid_q & ~err;
   assign misalign_err = err;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with an accepted-fetch address scoreboard.
module tb_pc_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        branch_taken, jump, jr, stall, imem_ready;
   logic [31:0] branch_target, jump_target, jr_target;

   logic [31:0] pc_plus4, pc_out, imem_addr;
   logic        imem_req, instr_valid, misalign_err;
   logic [31:0] w_plus4, w_pc, w_addr;
   logic        w_req, w_valid, w_err;

   int unsigned n_total;
   int unsigned n_pass;
   logic [31:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC adder feeding each instance: second operand tied to 4.
   assign pc_plus4 = pc_out + 32'd4;
   assign w_plus4  = w_pc + 32'd4;

   pc_fetch_ctrl dut (
      .clk(clk), .rst(rst), .pc_plus4(pc_plus4),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
      .stall(stall), .imem_ready(imem_ready), .pc_out(pc_out), .imem_req(imem_req),
      .imem_addr(imem_addr), .instr_valid(instr_valid), .misalign_err(misalign_err)
   );

   pc_fetch_ctrl #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .rst(rst), .pc_plus4(w_plus4),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
      .stall(stall), .imem_ready(imem_ready), .pc_out(w_pc), .imem_req(w_req),
      .imem_addr(w_addr), .instr_valid(w_valid), .misalign_err(w_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_total++;
      assert (obs === want) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, want);
   endtask

   task automatic check1(input string tag, input logic obs, input logic want);
      n_total++;
      assert (obs === want) n_pass++;
      else $error("FAIL %s: got %b expected %b", tag, obs, want);
   endtask

   task automatic clear_redirects();
      branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
   endtask

   // Sample at the falling edge; every accepted fetch pops one expected address.
   task automatic at_neg();
      logic [31:0] want;
      @(negedge clk);
      if (instr_valid === 1'b1) begin
         want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         check("sb_addr", imem_addr, want);
      end
      check("addr_eq_pc", imem_addr, pc_out);
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_total = 0; n_pass = 0;
      rst = 1'b0; stall = 1'b0; imem_ready = 1'b0;
      clear_redirects();
      branch_target = '0; jump_target = '0; jr_target = '0;
      #1 rst = 1'b1;
      #1;
      check ("rst_pc",     pc_out, 32'h0);
      check1("rst_req",    imem_req, 1'b0);
      check1("rst_valid",  instr_valid, 1'b0);
      check1("rst_err",    misalign_err, 1'b0);
      check ("wrap_rst_pc", w_pc, 32'hFFFF_FFF8);
      check1("wrap_rst_req", w_req, 1'b0);
      check1("wrap_rst_err", w_err, 1'b0);

      @(posedge clk); #1;
      rst = 1'b0; imem_ready = 1'b1;
      at_neg(); check1("boot_req", imem_req, 1'b0); to_next();

      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(32'(4 * i));
         at_neg();
         check1("seq_valid", instr_valid, 1'b1);
         check1("seq_req", imem_req, 1'b1);
         check ("wrap_addr", w_addr, 32'hFFFF_FFF8 + 32'(4 * i));
         check1("wrap_valid", w_valid, 1'b1);
         to_next();
      end

      // Wait on pc 0x10 with a jr arriving before completion.
      imem_ready = 1'b0; jr = 1'b1; jr_target = 32'h40;
      at_neg(); check("wait_addr", imem_addr, 32'h10); check1("wait_valid", instr_valid, 1'b0); to_next();
      jr = 1'b0;
      repeat (2) begin at_neg(); check1("wait_req", imem_req, 1'b1); to_next(); end
      imem_ready = 1'b1;
      at_neg(); check1("pend_squash", instr_valid, 1'b0); to_next();
      exp_q.push_back(32'h40);
      at_neg(); check("jr_addr", imem_addr, 32'h40); to_next();

      // Jump beats branch on a completing fetch.
      jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200;
      at_neg(); check1("redir_squash", instr_valid, 1'b0); to_next();
      clear_redirects();
      exp_q.push_back(32'h100);
      at_neg(); check("jump_addr", imem_addr, 32'h100); to_next();

      // jr beats jump.
      jr = 1'b1; jr_target = 32'h20; jump = 1'b1; jump_target = 32'h300;
      at_neg(); to_next();
      clear_redirects();

      // Stall at pc 0x20 with a branch captured while held.
      imem_ready = 1'b0; stall = 1'b1;
      at_neg(); check1("stall_entry_req", imem_req, 1'b1); check("stall_addr", imem_addr, 32'h20); to_next();
      at_neg(); check1("hold_req", imem_req, 1'b0); to_next();
      branch_taken = 1'b1; branch_target = 32'h80;
      at_neg(); check1("hold_req_br", imem_req, 1'b0); check1("hold_valid", instr_valid, 1'b0); to_next();
      branch_taken = 1'b0;
      at_neg(); check("hold_pc", pc_out, 32'h20); check1("hold_req2", imem_req, 1'b0); to_next();
      stall = 1'b0; imem_ready = 1'b1;
      at_neg(); check1("release_req", imem_req, 1'b0); to_next();
      exp_q.push_back(32'h80);
      at_neg(); check("release_addr", imem_addr, 32'h80); check1("release_req2", imem_req, 1'b1); to_next();

      // Asynchronous reset in the middle of a wait at pc 0x30.
      jump = 1'b1; jump_target = 32'h30;
      at_neg(); to_next();
      jump = 1'b0; imem_ready = 1'b0;
      at_neg(); check("pre_rst_addr", imem_addr, 32'h30);
      #2 rst = 1'b1;
      #1;
      check1("async_rst_req", imem_req, 1'b0);
      check ("async_rst_pc", pc_out, 32'h0);
      check1("async_rst_valid", instr_valid, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; imem_ready = 1'b1;
      at_neg(); check1("boot2_req", imem_req, 1'b0); to_next();

      // Misaligned jump target from pc 0.
      jump = 1'b1; jump_target = 32'h102;
`ifdef PC_MISALIGN_CHECK_EN
      at_neg(); check1("mis_valid", instr_valid, 1'b0); to_next();
      jump = 1'b0;
      at_neg(); check1("mis_err", misalign_err, 1'b1); check("mis_pc", pc_out, 32'h0);
      check1("mis_req", imem_req, 1'b0); to_next();
      at_neg(); check1("mis_sticky", misalign_err, 1'b1); check1("mis_req2", imem_req, 1'b0);
      check1("mis_valid2", instr_valid, 1'b0); to_next();
`else
      at_neg(); check1("align_valid", instr_valid, 1'b0); check1("align_err", misalign_err, 1'b0); to_next();
      jump = 1'b0;
      exp_q.push_back(32'h100);
      at_neg(); check("align_addr", imem_addr, 32'h100); check1("align_err2", misalign_err, 1'b0); to_next();
`endif

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
